// File: rtl/bar_fifo.sv
// bar_fifo: DEPTH-entry show-ahead elastic buffer on a bar valid/ready channel
module bar_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                x_data_i,
  input  logic                       x_valid_i,
  output logic                       x_ready_o,
  output logic [31:0]                y_data_o,
  output logic                       y_valid_o,
  input  logic                       y_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push, pop;
  // handshake, occupancy and pointer next-state; x_ready never looks at y_ready
  always_comb begin
    x_ready_o = rst_n && (count_q != FULL);
    y_valid_o = count_q != '0;
    y_data_o  = mem_q[rd_ptr_q];
    level_o   = count_q;
    push      = x_valid_i && x_ready_o;
    pop       = y_valid_o && y_ready_i;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + LW'(push) - LW'(pop);
  end
  // state registers and storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= x_data_i;
    end
  end
endmodule

// File: tb/tb_bar_fifo.sv
// tb_bar_fifo: directed self-checking bench for bar_fifo
module tb_bar_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] x_data_i;
  logic        x_valid_i;
  logic        x_ready_o;
  logic [31:0] y_data_o;
  logic        y_valid_o;
  logic        y_ready_i;
  logic [2:0]  level_o;
  int          n_chk = 0;
  int          n_fail = 0;

  bar_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_data_i(x_data_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .y_data_o(y_data_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i),
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] nxt;
    logic        ep, eo;
    int          popped, cnt, guard;
    rst_n = 1'b0; x_valid_i = 1'b1; x_data_i = 32'hDEAD; y_ready_i = 1'b0;
    #2;
    chk("rst_x_ready", 32'(x_ready_o), 0);
    chk("rst_y_valid", 32'(y_valid_o), 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_y_data", y_data_o, 0);
    tick(); tick();
    chk("rst_hold_level", 32'(level_o), 0);
    x_valid_i = 1'b0; rst_n = 1'b1;
    #1;
    chk("rel_x_ready", 32'(x_ready_o), 1);
    tick();
    chk("rel_level", 32'(level_o), 0);

    for (int i = 1; i <= 4; i++) begin
      x_data_i = 32'(i); x_valid_i = 1'b1;
      tick();
    end
    chk("fill_level", 32'(level_o), 4);
    chk("fill_x_ready", 32'(x_ready_o), 0);
    chk("fill_head", y_data_o, 32'h1);
    x_data_i = 32'h5;
    tick();
    chk("full_ignore_level", 32'(level_o), 4);
    chk("full_ignore_head", y_data_o, 32'h1);
    x_valid_i = 1'b0; y_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(y_valid_o), 1);
      chk("drain_data", y_data_o, 32'(i));
      tick();
    end
    chk("drain_level", 32'(level_o), 0);
    chk("drain_empty", 32'(y_valid_o), 0);

    x_valid_i = 1'b1; x_data_i = 32'd100;
    chk("stream_no_wt", 32'(y_valid_o), 0);
    tick();
    chk("stream_first_valid", 32'(y_valid_o), 1);
    chk("stream_first_data", y_data_o, 32'd100);
    chk("stream_first_level", 32'(level_o), 1);
    for (int k = 1; k <= 8; k++) begin
      x_data_i = 32'(100 + k);
      tick();
      chk("stream_data", y_data_o, 32'(100 + k));
      chk("stream_level", 32'(level_o), 1);
    end
    x_valid_i = 1'b0;
    tick();
    chk("stream_end_level", 32'(level_o), 0);

    y_ready_i = 1'b0; x_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_data_i = 32'(16 + i);
      tick();
    end
    chk("full2_level", 32'(level_o), 4);
    x_data_i = 32'h14; y_ready_i = 1'b1;
    chk("full2_x_ready", 32'(x_ready_o), 0);
    tick();
    chk("popfull_level", 32'(level_o), 3);
    chk("popfull_head", y_data_o, 32'h11);
    chk("popfull_x_ready", 32'(x_ready_o), 1);
    tick();
    chk("pushpop_level", 32'(level_o), 3);
    chk("pushpop_head", y_data_o, 32'h12);
    x_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("full2_drain", y_data_o, 32'(18 + i));
      tick();
    end
    chk("full2_end_level", 32'(level_o), 0);

    popped = 0; nxt = 32'h1000;
    for (int r = 0; r < 10; r++) begin
      cnt = 0; guard = 0;
      while (cnt < 3 && guard < 50) begin
        x_valid_i = 1'b1; x_data_i = nxt; y_ready_i = 1'($urandom_range(0, 1));
        #1;
        ep = q.size() != 4;
        eo = q.size() != 0 && y_ready_i;
        chk("wrap_x_ready", 32'(x_ready_o), 32'(ep));
        chk("wrap_level", 32'(level_o), 32'(q.size()));
        chk("wrap_y_valid", 32'(y_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) chk("wrap_data", y_data_o, q[0]);
        tick();
        if (eo) begin void'(q.pop_front()); popped++; end
        if (ep) begin q.push_back(nxt); nxt++; cnt++; end
        guard++;
      end
      chk("wrap_push_bound", 32'(cnt), 3);
      x_valid_i = 1'b0; y_ready_i = 1'b1; guard = 0;
      while (q.size() != 0 && guard < 10) begin
        chk("wrap_drain", y_data_o, q[0]);
        tick();
        void'(q.pop_front()); popped++; guard++;
      end
      chk("wrap_round_empty", 32'(level_o), 0);
    end
    chk("wrap_popped", 32'(popped), 30);

    y_ready_i = 1'b0; x_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_data_i = 32'(32'h50 + i);
      tick();
    end
    x_valid_i = 1'b0;
    chk("mid_pre_level", 32'(level_o), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_y_valid", 32'(y_valid_o), 0);
    chk("mid_level", 32'(level_o), 0);
    chk("mid_x_ready", 32'(x_ready_o), 0);
    chk("mid_y_data", y_data_o, 0);
    #1;
    rst_n = 1'b1;
    x_valid_i = 1'b1; x_data_i = 32'hAB;
    tick();
    x_valid_i = 1'b0;
    chk("post_y_valid", 32'(y_valid_o), 1);
    chk("post_y_data", y_data_o, 32'hAB);
    chk("post_level", 32'(level_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
